// File: rtl/truss_timeout_pkg.sv
// rtl/truss_timeout_pkg.sv - shared state encoding and default widths for the timeout timer
package truss_timeout_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    WARN    = 2'd2,
    EXPIRED = 2'd3
  } timeout_state_e;

  localparam int DEF_CNT_W = 32;
  localparam int DEF_EXP_W = 8;

endpackage

// File: rtl/truss_sat_counter.sv
// rtl/truss_sat_counter.sv - up-counter that sticks at all-ones
module truss_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // count increment requests, holding at the maximum value instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/truss_timeout_timer.sv
// rtl/truss_timeout_timer.sv - kick-reloaded timeout timer with warning level; TRUSS_TIMEOUT_AUTO_REARM_EN selects auto re-arm after expiry
module truss_timeout_timer
  import truss_timeout_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int EXP_W = DEF_EXP_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             arm,
  input  logic             kick,
  input  logic             disarm,
  input  logic             clear,
  input  logic [CNT_W-1:0] timeout_cycles,
  input  logic [CNT_W-1:0] warn_cycles,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] count,
  output logic             warning,
  output logic             timeout,
  output logic             expired,
  output logic [EXP_W-1:0] expire_cnt
);

  timeout_state_e   r_state;
  timeout_state_e   w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic [CNT_W-1:0] r_t;
  logic [CNT_W-1:0] w_t_nxt;
  logic [CNT_W-1:0] r_w;
  logic [CNT_W-1:0] w_w_nxt;
  logic [CNT_W-1:0] w_dec;
  logic             w_expire;
  logic             r_warning;
  logic             r_timeout;
  logic             r_expired;

  // a running count sits in WARN once it is at or below the warning threshold
  function automatic timeout_state_e phase_of(input logic [CNT_W-1:0] cnt,
                                              input logic [CNT_W-1:0] thr);
    return (cnt <= thr) ? WARN : ARMED;
  endfunction

  assign w_dec = r_count - CNT_W'(1);

  // next state, next count and latched limits; disarm beats kick beats expiry beats decrement
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_t_nxt     = r_t;
    w_w_nxt     = r_w;
    w_expire    = 1'b0;
    case (r_state)
      IDLE: begin
        if (arm) begin
          w_t_nxt     = timeout_cycles;
          w_w_nxt     = warn_cycles;
          w_count_nxt = timeout_cycles;
          if (timeout_cycles == '0) begin
            w_state_nxt = EXPIRED;
            w_expire    = 1'b1;
          end else begin
            w_state_nxt = phase_of(timeout_cycles, warn_cycles);
          end
        end
      end
      ARMED, WARN: begin
        if (disarm) begin
          w_state_nxt = IDLE;
          w_count_nxt = '0;
        end else if (kick) begin
          w_count_nxt = r_t;
          w_state_nxt = phase_of(r_t, r_w);
        end else if (r_count == CNT_W'(1)) begin
          w_state_nxt = EXPIRED;
          w_count_nxt = '0;
          w_expire    = 1'b1;
        end else if (r_count != '0) begin
          w_count_nxt = w_dec;
          w_state_nxt = phase_of(w_dec, r_w);
        end
      end
      EXPIRED: begin
`ifdef TRUSS_TIMEOUT_AUTO_REARM_EN
        // a zero limit re-expires every cycle rather than running a zero-length count
        if (r_t == '0) begin
          w_expire = 1'b1;
        end else begin
          w_count_nxt = r_t;
          w_state_nxt = phase_of(r_t, r_w);
        end
`else
        if (clear) begin
          w_state_nxt = IDLE;
        end
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // state, counter, latched limits and registered status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_t       <= '0;
      r_w       <= '0;
      r_warning <= 1'b0;
      r_timeout <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_t       <= w_t_nxt;
      r_w       <= w_w_nxt;
      r_warning <= (w_state_nxt == WARN);
      r_timeout <= w_expire;
`ifdef TRUSS_TIMEOUT_AUTO_REARM_EN
      // sticky until acknowledged; a fresh expiry wins over a same-cycle clear
      if (w_expire) begin
        r_expired <= 1'b1;
      end else if (clear) begin
        r_expired <= 1'b0;
      end
`else
      r_expired <= (w_state_nxt == EXPIRED);
`endif
    end
  end

  truss_sat_counter #(
    .W(EXP_W)
  ) u_expire_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .i_inc (w_expire),
    .o_cnt (expire_cnt)
  );

  assign state   = r_state;
  assign count   = r_count;
  assign warning = r_warning;
  assign timeout = r_timeout;
  assign expired = r_expired;

endmodule

// File: tb/tb_truss_timeout_timer.sv
// tb/tb_truss_timeout_timer.sv - directed plus randomized checks of the timeout timer against a behavioural model
module tb_truss_timeout_timer;

  logic        clk;
  logic        reset_n;
  logic        arm;
  logic        kick;
  logic        disarm;
  logic        clear;
  logic [31:0] timeout_cycles;
  logic [31:0] warn_cycles;
  logic [1:0]  state;
  logic [31:0] count;
  logic        warning;
  logic        timeout;
  logic        expired;
  logic [7:0]  expire_cnt;
  logic [1:0]  state2;
  logic [31:0] count2;
  logic        warning2;
  logic        timeout2;
  logic        expired2;
  logic [1:0]  expire_cnt2;

  int n_cmp;
  int n_fail;

  // reference model: mode 0 idle, 1 counting, 2 expired
  int          m_mode;
  logic [31:0] m_left;
  logic [31:0] m_T;
  logic [31:0] m_W;
  int          m_n;
  bit          m_pulse;
  bit          m_flag;

  truss_timeout_timer #(.CNT_W(32), .EXP_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .arm(arm), .kick(kick), .disarm(disarm), .clear(clear),
    .timeout_cycles(timeout_cycles), .warn_cycles(warn_cycles),
    .state(state), .count(count), .warning(warning), .timeout(timeout),
    .expired(expired), .expire_cnt(expire_cnt)
  );

  truss_timeout_timer #(.CNT_W(32), .EXP_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .arm(arm), .kick(kick), .disarm(disarm), .clear(clear),
    .timeout_cycles(timeout_cycles), .warn_cycles(warn_cycles),
    .state(state2), .count(count2), .warning(warning2), .timeout(timeout2),
    .expired(expired2), .expire_cnt(expire_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_T = 0; m_W = 0; m_n = 0; m_pulse = 0; m_flag = 0;
  endtask

  task automatic expire_now();
    m_mode = 2; m_left = 0; m_pulse = 1; m_n++; m_flag = 1;
  endtask

  task automatic model_step();
    m_pulse = 0;
`ifdef TRUSS_TIMEOUT_AUTO_REARM_EN
    if (clear) m_flag = 0;
`endif
    case (m_mode)
      0: if (arm) begin
           m_T = timeout_cycles; m_W = warn_cycles;
           if (m_T == 0) expire_now();
           else begin m_mode = 1; m_left = m_T; end
         end
      1: if (disarm) begin m_mode = 0; m_left = 0; end
         else if (kick) m_left = m_T;
         else if (m_left == 1) expire_now();
         else m_left = m_left - 1;
      default: begin
`ifdef TRUSS_TIMEOUT_AUTO_REARM_EN
        if (m_T == 0) expire_now();
        else begin m_mode = 1; m_left = m_T; end
`else
        if (clear) begin m_mode = 0; m_flag = 0; end
`endif
      end
    endcase
  endtask

  function automatic logic [1:0] m_state();
    if (m_mode == 0) return 2'd0;
    if (m_mode == 2) return 2'd3;
    return (m_left <= m_W) ? 2'd2 : 2'd1;
  endfunction

  task automatic check_all();
    chk("state", state, m_state());
    chk("count", count, m_left);
    chk("warning", warning, m_state() == 2'd2);
    chk("timeout", timeout, m_pulse);
    chk("expired", expired, m_flag);
    chk("expire_cnt", expire_cnt, (m_n > 255) ? 255 : m_n);
    chk("expire_cnt_sat2", expire_cnt2, (m_n > 3) ? 3 : m_n);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_arm(input logic [31:0] t, input logic [31:0] w);
    timeout_cycles = t; warn_cycles = w; arm = 1; cyc(); arm = 0;
  endtask

  task automatic go_idle();
    for (int i = 0; i < 4 && m_mode != 0; i++) begin
      clear = 1; cyc(); clear = 0;
      disarm = 1; cyc(); disarm = 0;
    end
    chk("go_idle", state, 2'd0);
  endtask

  task automatic run_until_left(input logic [31:0] target, input string tag);
    int budget;
    budget = 0;
    while (!(m_mode == 1 && m_left == target) && budget < 200) begin
      cyc(); budget++;
    end
    if (budget >= 200) chk({tag, "_timeout"}, 1'b0, 1'b1);
  endtask

  initial begin
    int pulses;
    int last_pulse;
    n_cmp = 0; n_fail = 0;
    arm = 0; kick = 0; disarm = 0; clear = 0;
    timeout_cycles = 0; warn_cycles = 0;
    reset_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset_n = 1;

    // basic expiry: arm cycle, counts 10..1, then EXPIRED on the eleventh edge
    do_arm(32'd10, 32'd3);
    chk("basic_first", count, 32'd10);
    repeat (10) cyc();
    chk("basic_pulse", timeout, 1'b1);
    chk("basic_expcnt", expire_cnt, 8'd1);
    repeat (3) cyc();
    go_idle();

    // kick on the count=1 cycle prevents expiry and reloads
    do_arm(32'd8, 32'd2);
    run_until_left(32'd1, "kick_wait");
    chk("kick_warn_before", warning, 1'b1);
    kick = 1; cyc(); kick = 0;
    chk("kick_count", count, 32'd8);
    chk("kick_state", state, 2'd1);
    chk("kick_warning", warning, 1'b0);
    chk("kick_nopulse", timeout, 1'b0);
    repeat (3) cyc();

    // disarm beats kick
    run_until_left(32'd5, "prio_wait");
    disarm = 1; kick = 1; cyc(); disarm = 0; kick = 0;
    chk("prio_state", state, 2'd0);
    chk("prio_count", count, 32'd0);

    // T=0 expires straight from arm
    do_arm(32'd0, 32'd0);
    chk("t0_state", state, 2'd3);
    chk("t0_pulse", timeout, 1'b1);
    go_idle();

    // T equal to W starts in WARN
    do_arm(32'd4, 32'd4);
    chk("tw_state", state, 2'd2);
    chk("tw_warning", warning, 1'b1);
    repeat (2) cyc();
    go_idle();

    // reload uses the latched limit, not the live input
    do_arm(32'd12, 32'd2);
    repeat (3) cyc();
    timeout_cycles = $urandom_range(13, 1000);
    warn_cycles = $urandom_range(13, 1000);
    kick = 1; cyc(); kick = 0;
    chk("latch_count", count, 32'd12);
    repeat (2) cyc();
    go_idle();

    // repeated expiries saturate the narrow counter
    for (int k = 0; k < 5; k++) begin
      do_arm(32'd1, 32'd0);
      cyc();
      go_idle();
    end
    chk("sat2", expire_cnt2, 2'd3);

`ifdef TRUSS_TIMEOUT_AUTO_REARM_EN
    // automatic re-arm: pulses every T+1 cycles, flag sticky until clear
    do_arm(32'd5, 32'd1);
    pulses = 0; last_pulse = 0;
    for (int c = 1; c <= 20; c++) begin
      cyc();
      if (timeout) begin
        if (pulses > 0) chk("rearm_period", c - last_pulse, 6);
        pulses++; last_pulse = c;
      end
      if (pulses > 0) chk("rearm_sticky", expired, 1'b1);
    end
    chk("rearm_pulses", pulses >= 3, 1'b1);
    go_idle();
    chk("rearm_cleared", expired, 1'b0);
`else
    pulses = 0; last_pulse = 0;
`endif

    // randomized control traffic against the model
    for (int c = 0; c < 400; c++) begin
      arm    = ($urandom_range(0, 7) == 0);
      kick   = ($urandom_range(0, 9) == 0);
      disarm = ($urandom_range(0, 39) == 0);
      clear  = ($urandom_range(0, 9) == 0);
      timeout_cycles = $urandom_range(0, 12);
      warn_cycles    = $urandom_range(0, 6);
      cyc();
    end
    arm = 0; kick = 0; disarm = 0; clear = 0;
    go_idle();

    // asynchronous reset while in WARN
    do_arm(32'd6, 32'd5);
    cyc();
    chk("rst_pre_warn", state, 2'd2);
    #2;
    reset_n = 0;
    model_reset();
    #1;
    check_all();
    #2;
    reset_n = 1;
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
